// File: rtl/sram_controller.sv
// Word-wide load/store front end for a 16-bit asynchronous SRAM.
// Each word access is split into a low and a high half-word phase.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        op_wr;
    logic [16:0] idx;
    logic [31:0] wdata;

    logic        req, accept, last;
    logic        wr_nxt, drive_nxt;
    logic [16:0] idx_in, idx_nxt;
    logic [31:0] wdata_nxt;
    logic [17:0] addr_nxt;
    logic [15:0] dq_nxt;

    assign req    = wr_en | rd_en;
    assign idx_in = 17'((address - BASE_ADDR) >> 2);
    assign last   = (cnt == LAST);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = LO;
                    cnt_nxt   = '0;
                end
            end
            LO: begin
                if (last) begin
                    state_nxt = HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            HI: begin
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) ready = 1'b1;

        // Pad outputs are registered, so they are computed from the state being entered.
        wr_nxt    = accept ? wr_en : op_wr;
        idx_nxt   = accept ? idx_in : idx;
        wdata_nxt = accept ? write_data : wdata;
        drive_nxt = wr_nxt && (state_nxt == LO || state_nxt == HI);
        addr_nxt  = sram_addr;
        dq_nxt    = sram_dq_out;
        if (state_nxt == LO) begin
            addr_nxt = {idx_nxt, 1'b0};
            dq_nxt   = wdata_nxt[15:0];
        end else if (state_nxt == HI) begin
            addr_nxt = {idx_nxt, 1'b1};
            dq_nxt   = wdata_nxt[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx         <= '0;
            wdata       <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sram_addr   <= addr_nxt;
            sram_dq_out <= dq_nxt;
            sram_dq_oe  <= drive_nxt;
            sram_we_n   <= ~drive_nxt;
            if (accept) begin
                op_wr <= wr_en;
                idx   <= idx_in;
                wdata <= write_data;
            end
            if (state == LO && last && !op_wr) read_data[15:0]  <= sram_dq_in;
            if (state == HI && last && !op_wr) read_data[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: W=2 controller on a small SRAM model, plus a W=1 controller
// for back-to-back throughput.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        wr_en1, rd_en1;
    logic [31:0] address1, write_data1, read_data1;
    logic        ready1, sram_dq_oe1, sram_we_n1;
    logic [17:0] sram_addr1;
    logic [15:0] sram_dq_out1, sram_dq_in1;

    logic [15:0] mem [256];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
        .write_data(write_data1), .read_data(read_data1), .ready(ready1),
        .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
        .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
    );

    always @(posedge clk) if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq_out;
    assign sram_dq_in  = mem[sram_addr[7:0]];
    assign sram_dq_in1 = sram_addr1[15:0] + 16'h1000;

    // One full access on the W=2 controller; inputs are scrambled after acceptance.
    task automatic run_access(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [17:0] lo_addr,
                              input logic [31:0] exp_rd);
        logic [15:0] half;
        wr_en = w; rd_en = r; address = a; write_data = d;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL accept_ready: got %b want 0", ready); end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_0000; write_data = 32'h1357_9BDF;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            half = (c < 2) ? d[15:0] : d[31:16];
            n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL phase_ready c%0d: got %b want 0", c, ready); end
            n_cmp++; if (sram_addr !== (lo_addr | 18'(c / 2))) begin n_bad++; $display("FAIL phase_addr c%0d: got %h want %h", c, sram_addr, lo_addr | 18'(c / 2)); end
            n_cmp++; if (sram_we_n !== ~w || sram_dq_oe !== w) begin n_bad++; $display("FAIL phase_strobe c%0d: got we_n=%b oe=%b want we_n=%b oe=%b", c, sram_we_n, sram_dq_oe, ~w, w); end
            if (w) begin
                n_cmp++; if (sram_dq_out !== half) begin n_bad++; $display("FAIL phase_dq c%0d: got %h want %h", c, sram_dq_out, half); end
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL done_ready: got %b want 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL done_strobe: got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
        n_cmp++; if (read_data !== exp_rd) begin n_bad++; $display("FAIL done_read_data: got %h want %h", read_data, exp_rd); end
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1 || read_data !== exp_rd) begin n_bad++; $display("FAIL idle_after: got ready=%b rd=%h want 1/%h", ready, read_data, exp_rd); end
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1024; write_data = 32'h0;
        wr_en1 = 1'b0; rd_en1 = 1'b0; address1 = 32'd1044; write_data1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got we_n=%b oe=%b want 1/0", sram_we_n, sram_dq_oe); end
        n_cmp++; if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin n_bad++; $display("FAIL reset_pads: got addr=%h dq=%h want 0/0", sram_addr, sram_dq_out); end
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        wr_en = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ready !== 1'b1 || sram_we_n !== 1'b1) begin n_bad++; $display("FAIL idle_no_req: got ready=%b we_n=%b want 1/1", ready, sram_we_n); end
    endtask

    task automatic test_write_read;
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 18'd0, 32'h0);
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hDEAD_BEEF);
    endtask

    task automatic test_addressing;
        run_access(1'b1, 1'b0, 32'd1036, 32'h1234_5678, 18'd6, 32'hDEAD_BEEF);
        run_access(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 32'h1234_5678);
        run_access(1'b1, 1'b0, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 32'h1234_5678);
        run_access(1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'hCAFE_F00D);
    endtask

    task automatic test_both_enables;
        run_access(1'b1, 1'b1, 32'd1028, 32'hA5A5_5A5A, 18'd2, 32'hCAFE_F00D);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hA5A5_5A5A);
    endtask

    task automatic test_reset_mid_read;
        wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024;
        @(posedge clk); #1;
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (sram_addr !== 18'd1 || ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_hi: got addr=%h ready=%b want 1/0", sram_addr, ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 1", ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL mid_rst_read_data: got %h want 0", read_data); end
        n_cmp++; if (sram_we_n !== 1'b1 || ready !== 1'b1 || sram_addr !== 18'h0) begin n_bad++; $display("FAIL mid_rst_idle: got we_n=%b ready=%b addr=%h want 1/1/0", sram_we_n, ready, sram_addr); end
        @(posedge clk); #1;
        run_access(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hDEAD_BEEF);
    endtask

    task automatic test_back_to_back;
        logic exp_rdy;
        rd_en1 = 1'b1; address1 = 32'd1044;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(posedge clk);
            #1;
            exp_rdy = ((k % 4) == 3);
            n_cmp++; if (ready1 !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready k%0d: got %b want %b", k, ready1, exp_rdy); end
            if ((k % 4) == 1 || (k % 4) == 2) begin
                n_cmp++; if (sram_addr1 !== 18'(9 + (k % 4))) begin n_bad++; $display("FAIL b2b_addr k%0d: got %h want %h", k, sram_addr1, 18'(9 + (k % 4))); end
            end
            if ((k % 4) == 3) begin
                n_cmp++; if (read_data1 !== 32'h100B_100A) begin n_bad++; $display("FAIL b2b_read_data k%0d: got %h want 100b100a", k, read_data1); end
            end
        end
        rd_en1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_read();
        test_addressing();
        test_both_enables();
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter BASE_ADDR, default 1024; data-memory base byte address subtracted from every request address.
REQ-002 Parameter WAIT_CYCLES, default 2, legal 1..15; clock cycles each SRAM half-word phase lasts.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  memory write request from EXE/MEM pipeline (MEM_W_EN).
REQ-006 rd_en  input  1  memory read request from EXE/MEM pipeline (MEM_R_EN).
REQ-007 address  input  32  byte address of word access (ALU result).
REQ-008 write_data  input  32  word to store (Val_Rm).
REQ-009 read_data  output  32  last completed read word, registered.
REQ-010 ready  output  1  0 = freeze pipeline; 1 = no access in progress or access completes this cycle.
REQ-011 sram_addr  output  18  SRAM half-word address, registered.
REQ-012 sram_dq_out  output  16  write data to SRAM pad.
REQ-013 sram_dq_oe  output  1  1 = controller drives SRAM data bus.
REQ-014 sram_dq_in  input  16  read data from SRAM pad.
REQ-015 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 States SHALL be IDLE, LO, HI, DONE; phase counter 4 bits.
REQ-017 Word index SHALL be (address - BASE_ADDR) >> 2, 32-bit arithmetic; sram_addr = {index[16:0], 0} in LO, {index[16:0], 1} in HI; upper index bits discarded (wrap modulo 2^18).
REQ-018 Request = wr_en | rd_en; both high SHALL be treated as write.
REQ-019 IDLE, no request: ready = 1, sram_we_n = 1, sram_dq_oe = 0, stay IDLE.
REQ-020 IDLE, request at cycle t: ready = 0 combinationally in cycle t; latch op, index, write_data; next state LO, counter cleared.
REQ-021 LO and HI SHALL each last exactly WAIT_CYCLES cycles, ready = 0 throughout; LO -> HI -> DONE.
REQ-022 Write: sram_dq_oe = 1, sram_we_n = 0 for all LO/HI cycles; sram_dq_out = write_data[15:0] in LO, [31:16] in HI.
REQ-023 Read: sram_dq_oe = 0, sram_we_n = 1; sram_dq_in sampled on last LO cycle into read_data[15:0], last HI cycle into read_data[31:16].
REQ-024 DONE: one cycle, ready = 1, sram_we_n = 1, sram_dq_oe = 0, next state IDLE unconditionally; request inputs ignored in DONE.
REQ-025 Total: request accepted cycle t -> ready low cycles t..t+2*WAIT_CYCLES, high at t+2*WAIT_CYCLES+1 (DONE); next request earliest sampled at t+2*WAIT_CYCLES+2.
REQ-026 Inputs changing during LO/HI SHALL NOT affect the access in progress (latched copies used).
REQ-027 read_data SHALL hold its value through writes and idle cycles; updated only by reads.
REQ-028 Write SHALL never modify read_data.

Reset
REQ-029 rst high at a clock edge SHALL force IDLE, counter 0, read_data 0, sram_addr 0, sram_dq_out 0, sram_dq_oe 0, sram_we_n 1, regardless of state; access in progress abandoned.
REQ-030 During a cycle with rst high, ready SHALL be 1 and no request accepted.

Verification
REQ-031 Write: address 1024, write_data 0xDEADBEEF, W=2 -> ready low 5 cycles; sram_addr 0 with dq 0xBEEF 2 cycles, sram_addr 1 with dq 0xDEAD 2 cycles; we_n low 4 cycles.
REQ-032 Read back: rd_en, address 1024, SRAM model returns 0xBEEF/0xDEAD -> read_data 0xDEADBEEF in DONE cycle, ready high that cycle.
REQ-033 Address 1036 -> sram_addr 6 then 7; address 1020 -> index wraps, sram_addr 0x3FFFE then 0x3FFFF.
REQ-034 wr_en and rd_en both high, address 1028 -> write performed, read_data unchanged.
REQ-035 rst asserted in HI of a read -> next cycle IDLE, read_data 0, we_n 1, ready 1; fresh request then completes normally.
REQ-036 Back-to-back requests held high, W=1 -> ready pattern 0,0,0,1 repeating; no access skipped or duplicated.
